// File: rtl/kb_pkg.sv
// Shared types and constants for the PS/2 keyboard mailbox writer:
// frame FSM states, scan-code constants and event-word layout.
package kb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } frame_state_e;

    localparam logic [7:0] KB_PREFIX_EXT = 8'hE0;
    localparam logic [7:0] KB_PREFIX_BRK = 8'hF0;
    localparam logic [7:0] KB_LSHIFT     = 8'h12;
    localparam logic [7:0] KB_RSHIFT     = 8'h59;
    localparam logic [7:0] KB_CTRL       = 8'h14;

    localparam int EV_CODE_LSB  = 0;
    localparam int EV_EXT_BIT   = 8;
    localparam int EV_BRK_BIT   = 9;
    localparam int EV_SHIFT_BIT = 10;
    localparam int EV_CTRL_BIT  = 11;
    localparam int EV_SEQ_LSB   = 16;

    function automatic logic [31:0] kb_event_word(
        input logic [15:0] seq,
        input logic        ctrl,
        input logic        shift,
        input logic        brk,
        input logic        ext,
        input logic [7:0]  code
    );
        logic [31:0] w;
        w                      = '0;
        w[EV_CODE_LSB +: 8]    = code;
        w[EV_EXT_BIT]          = ext;
        w[EV_BRK_BIT]          = brk;
        w[EV_SHIFT_BIT]        = shift;
        w[EV_CTRL_BIT]         = ctrl;
        w[EV_SEQ_LSB +: 16]    = seq;
        return w;
    endfunction

endpackage

// File: rtl/ps2_rx_frame.sv
// PS/2 receive framer: input synchronizers, falling-edge detect, 11-bit
// frame FSM with odd-parity/stop check and an inactivity timeout.
module ps2_rx_frame
    import kb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       byte_valid,
    output logic [7:0] rx_byte,
    output logic       err
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CYCLES - 1);

    logic [1:0]    clk_sync_q, clk_sync_d;
    logic [1:0]    dat_sync_q, dat_sync_d;
    logic          clk_prev_q;
    frame_state_e  state_q, state_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shreg_q, shreg_d;
    logic          par_q, par_d;
    logic [TW-1:0] tmo_q, tmo_d;

    logic fall;
    logic din;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_sync_q <= '0;
            dat_sync_q <= '0;
            clk_prev_q <= 1'b0;
            state_q    <= ST_IDLE;
            bit_cnt_q  <= '0;
            shreg_q    <= '0;
            par_q      <= 1'b0;
            tmo_q      <= '0;
        end else begin
            clk_sync_q <= clk_sync_d;
            dat_sync_q <= dat_sync_d;
            clk_prev_q <= clk_sync_q[1];
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shreg_q    <= shreg_d;
            par_q      <= par_d;
            tmo_q      <= tmo_d;
        end
    end

    assign fall    = clk_prev_q & ~clk_sync_q[1];
    assign din     = dat_sync_q[1];
    assign rx_byte = shreg_q;

    always_comb begin
        clk_sync_d = {clk_sync_q[0], ps2_clk};
        dat_sync_d = {dat_sync_q[0], ps2_data};
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shreg_d    = shreg_q;
        par_d      = par_q;
        byte_valid = 1'b0;
        err        = 1'b0;
        // Saturating idle counter; an edge always clears it, so a timeout
        // can never be raised in the same cycle as an edge.
        if (fall)                tmo_d = '0;
        else if (tmo_q == TMO_MAX) tmo_d = tmo_q;
        else                     tmo_d = tmo_q + TW'(1);

        if (fall) begin
            case (state_q)
                ST_IDLE: begin
                    if (!din) begin
                        state_d   = ST_DATA;
                        bit_cnt_d = '0;
                    end
                end
                ST_DATA: begin
                    shreg_d   = {din, shreg_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) state_d = ST_PARITY;
                end
                ST_PARITY: begin
                    par_d   = din;
                    state_d = ST_STOP;
                end
                ST_STOP: begin
                    state_d = ST_IDLE;
                    if ((^{shreg_q, par_q}) && din) byte_valid = 1'b1;
                    else                            err        = 1'b1;
                end
                default: state_d = ST_IDLE;
            endcase
        end else if (state_q != ST_IDLE && tmo_q == TMO_MAX) begin
            state_d = ST_IDLE;
            err     = 1'b1;
        end
    end

endmodule

// File: rtl/ps2_kb_writer.sv
// PS/2 keyboard event producer for the kb_info mailbox: decodes E0/F0
// sequences, tracks shift/ctrl and writes sequenced event words.
// Optional auto-repeat suppression: define KB_TYPEMATIC_FILTER_EN.
module ps2_kb_writer
    import kb_pkg::*;
#(
    parameter logic [31:0] KB_INFO_BASE   = 32'h00500000,
    parameter int          TIMEOUT_CYCLES = 50000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic [31:0] kb_wraddr,
    output logic [31:0] kb_wrdata,
    output logic        kb_we,
    output logic        frame_err
);

    logic       rx_valid;
    logic [7:0] rx_byte;
    logic       rx_err;

    ps2_rx_frame #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_rx (
        .clk        (clk),
        .rst_n      (rst_n),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .byte_valid (rx_valid),
        .rx_byte    (rx_byte),
        .err        (rx_err)
    );

    logic        ext_q, ext_d, brk_q, brk_d;
    logic        shift_q, shift_d, ctrl_q, ctrl_d;
    logic [15:0] seq_q, seq_d;
    logic [31:0] wrdata_q, wrdata_d;
    logic        we_q, we_d, ferr_q, ferr_d;
    logic        suppress;
`ifdef KB_TYPEMATIC_FILTER_EN
    logic        lm_valid_q, lm_valid_d, lm_ext_q, lm_ext_d;
    logic [7:0]  lm_code_q, lm_code_d;
    logic        lm_match;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ext_q      <= 1'b0;
            brk_q      <= 1'b0;
            shift_q    <= 1'b0;
            ctrl_q     <= 1'b0;
            seq_q      <= '0;
            wrdata_q   <= '0;
            we_q       <= 1'b0;
            ferr_q     <= 1'b0;
`ifdef KB_TYPEMATIC_FILTER_EN
            lm_valid_q <= 1'b0;
            lm_ext_q   <= 1'b0;
            lm_code_q  <= '0;
`endif
        end else begin
            ext_q      <= ext_d;
            brk_q      <= brk_d;
            shift_q    <= shift_d;
            ctrl_q     <= ctrl_d;
            seq_q      <= seq_d;
            wrdata_q   <= wrdata_d;
            we_q       <= we_d;
            ferr_q     <= ferr_d;
`ifdef KB_TYPEMATIC_FILTER_EN
            lm_valid_q <= lm_valid_d;
            lm_ext_q   <= lm_ext_d;
            lm_code_q  <= lm_code_d;
`endif
        end
    end

    always_comb begin
        ext_d      = ext_q;
        brk_d      = brk_q;
        shift_d    = shift_q;
        ctrl_d     = ctrl_q;
        seq_d      = seq_q;
        wrdata_d   = wrdata_q;
        we_d       = 1'b0;
        ferr_d     = rx_err;
        suppress   = 1'b0;
`ifdef KB_TYPEMATIC_FILTER_EN
        lm_valid_d = lm_valid_q;
        lm_ext_d   = lm_ext_q;
        lm_code_d  = lm_code_q;
        lm_match   = lm_valid_q && (lm_ext_q == ext_q) && (lm_code_q == rx_byte);
`endif
        if (rx_err) begin
            ext_d = 1'b0;
            brk_d = 1'b0;
        end else if (rx_valid) begin
            if (rx_byte == KB_PREFIX_EXT) begin
                ext_d = 1'b1;
            end else if (rx_byte == KB_PREFIX_BRK) begin
                brk_d = 1'b1;
            end else begin
                if ((rx_byte == KB_LSHIFT || rx_byte == KB_RSHIFT) && !ext_q)
                    shift_d = !brk_q;
                if (rx_byte == KB_CTRL)
                    ctrl_d = !brk_q;
`ifdef KB_TYPEMATIC_FILTER_EN
                // Repeated makes of the held key are dropped; its break re-arms it.
                if (brk_q) begin
                    if (lm_match) lm_valid_d = 1'b0;
                end else if (lm_match) begin
                    suppress = 1'b1;
                end else begin
                    lm_valid_d = 1'b1;
                    lm_ext_d   = ext_q;
                    lm_code_d  = rx_byte;
                end
`endif
                if (!suppress) begin
                    seq_d    = seq_q + 16'd1;
                    we_d     = 1'b1;
                    wrdata_d = kb_event_word(seq_d, ctrl_d, shift_d, brk_q, ext_q, rx_byte);
                end
                ext_d = 1'b0;
                brk_d = 1'b0;
            end
        end
    end

    assign kb_wraddr = KB_INFO_BASE;
    assign kb_wrdata = wrdata_q;
    assign kb_we     = we_q;
    assign frame_err = ferr_q;

endmodule
